// File: rtl/smc_input_sequencer.sv
// Front-end sequencer for the SMC datapath: gathers six serial (W, V_GS, V_DS) beats,
// presents them as parallel buses to the combinational core and returns a registered result.
module smc_input_sequencer #(
  parameter int unsigned DW     = 3,
  parameter int unsigned N_SETS = 6,
  parameter int unsigned OW     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [1:0]           mode,
  input  logic [DW-1:0]        W,
  input  logic [DW-1:0]        V_GS,
  input  logic [DW-1:0]        V_DS,
  output logic [1:0]           smc_mode,
  output logic [DW*N_SETS-1:0] smc_w,
  output logic [DW*N_SETS-1:0] smc_vgs,
  output logic [DW*N_SETS-1:0] smc_vds,
  input  logic [OW-1:0]        smc_out_n,
  output logic                 busy,
  output logic                 out_valid,
  output logic [OW-1:0]        out_n
);

  localparam int unsigned CW = (N_SETS > 1) ? $clog2(N_SETS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, OUT} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic [DW*N_SETS-1:0]  w_q, w_d;
  logic [DW*N_SETS-1:0]  vgs_q, vgs_d;
  logic [DW*N_SETS-1:0]  vds_q, vds_d;
  logic                  busy_q, busy_d;
  logic                  out_valid_q, out_valid_d;
  logic [OW-1:0]         out_n_q, out_n_d;
  logic                  capture;
  logic [CW-1:0]         sel;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    w_d         = w_q;
    vgs_d       = vgs_q;
    vds_d       = vds_q;
    out_valid_d = 1'b0;
    out_n_d     = '0;
    capture     = 1'b0;
    sel         = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          sel     = '0;
          mode_d  = mode;
          cnt_d   = CW'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          capture = 1'b1;
          if (cnt_q == CW'(N_SETS - 1)) begin
            cnt_d   = '0;
            state_d = EVAL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          // Gap in the stream: drop the partial pattern; stale sets get overwritten next time.
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      EVAL: begin
        out_valid_d = 1'b1;
        out_n_d     = smc_out_n;
        state_d     = OUT;
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (capture) begin
      for (int unsigned k = 0; k < N_SETS; k++) begin
        if (CW'(k) == sel) begin
          w_d[DW*k +: DW]   = W;
          vgs_d[DW*k +: DW] = V_GS;
          vds_d[DW*k +: DW] = V_DS;
        end
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= '0;
      w_q         <= '0;
      vgs_q       <= '0;
      vds_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_n_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      w_q         <= w_d;
      vgs_q       <= vgs_d;
      vds_q       <= vds_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_n_q     <= out_n_d;
    end
  end

  assign smc_mode  = mode_q;
  assign smc_w     = w_q;
  assign smc_vgs   = vgs_q;
  assign smc_vds   = vds_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_n     = out_n_q;

endmodule

// File: tb/tb_smc_input_sequencer.sv
// Bench for smc_input_sequencer with a behavioural SMC core and a schedule-based reference model.
module tb_smc_input_sequencer;

  localparam int DW = 3;
  localparam int NS = 6;
  localparam int OW = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [1:0]        mode = '0;
  logic [DW-1:0]     W = '0, V_GS = '0, V_DS = '0;
  logic [1:0]        smc_mode;
  logic [DW*NS-1:0]  smc_w, smc_vgs, smc_vds;
  logic [OW-1:0]     smc_out_n;
  logic              busy, out_valid;
  logic [OW-1:0]     out_n;

  always #5 clk = ~clk;

  smc_input_sequencer #(.DW(DW), .N_SETS(NS), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
    .W(W), .V_GS(V_GS), .V_DS(V_DS),
    .smc_mode(smc_mode), .smc_w(smc_w), .smc_vgs(smc_vgs), .smc_vds(smc_vds),
    .smc_out_n(smc_out_n), .busy(busy), .out_valid(out_valid), .out_n(out_n)
  );

  // Behavioural SMC core: per-set Id (mode[0]=1) or gm (mode[0]=0), pick three largest
  // (mode[1]=1) or smallest, weighted 3/4/5.
  function automatic int id_gm(input int cur, input int w, input int g, input int d);
    int ov;
    ov = g - 1;
    if (ov <= 0) return 0;
    if (cur != 0) begin
      if (d < ov) return w * (2 * ov * d - d * d) / 3;
      return w * ov * ov / 3;
    end
    if (d < ov) return 2 * w * d / 3;
    return 2 * w * ov / 3;
  endfunction

  function automatic logic [OW-1:0] core_fn(input logic [1:0] m, input logic [DW*NS-1:0] w,
                                            input logic [DW*NS-1:0] g, input logic [DW*NS-1:0] d);
    int v[NS];
    int t;
    for (int k = 0; k < NS; k++)
      v[k] = id_gm(int'(m[0]), int'(w[DW*k +: DW]), int'(g[DW*k +: DW]), int'(d[DW*k +: DW]));
    for (int i = 0; i < NS - 1; i++)
      for (int j = 0; j < NS - 1 - i; j++)
        if (v[j] < v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    if (m[1]) return OW'(3 * v[0] + 4 * v[1] + 5 * v[2]);
    return OW'(3 * v[5] + 4 * v[4] + 5 * v[3]);
  endfunction

  assign smc_out_n = core_fn(smc_mode, smc_w, smc_vgs, smc_vds);

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model: a pattern accepted at cycle t captures beats t..t+NS-1, strobes the
  // result at t+NS+1 and is idle again at t+NS+2.
  int               cyc = 0;
  int               m_start = -1;
  int               urel;
  logic [1:0]       m_mode = '0;
  logic [DW*NS-1:0] m_w = '0, m_g = '0, m_d = '0;

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_start = -1;
      m_mode = '0; m_w = '0; m_g = '0; m_d = '0;
    end else begin
      if (m_start < 0) begin
        if (in_valid) begin
          m_start = cyc;
          m_mode = mode;
          m_w[0 +: DW] = W; m_g[0 +: DW] = V_GS; m_d[0 +: DW] = V_DS;
        end
      end else begin
        urel = cyc - m_start;
        if (urel <= NS - 1) begin
          if (in_valid) begin
            m_w[DW*urel +: DW] = W; m_g[DW*urel +: DW] = V_GS; m_d[DW*urel +: DW] = V_DS;
          end else begin
            m_start = -1;
          end
        end else if (urel == NS + 1) begin
          m_start = -1;
        end
      end
      cyc++;
    end
  end

  logic chk_en = 1'b0;
  int   ov_count = 0;
  int   mrel;
  logic e_ov;

  always begin
    @(negedge clk);
    if (rst_n && chk_en) begin
      mrel = cyc - m_start;
      e_ov = (m_start >= 0) && (mrel == NS + 1);
      chk("busy", 32'(busy), 32'(m_start >= 0));
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      chk("out_n", 32'(out_n), e_ov ? 32'(core_fn(m_mode, m_w, m_g, m_d)) : 32'd0);
      chk("smc_mode", 32'(smc_mode), 32'(m_mode));
      chk("smc_w", 32'(smc_w), 32'(m_w));
      chk("smc_vgs", 32'(smc_vgs), 32'(m_g));
      chk("smc_vds", 32'(smc_vds), 32'(m_d));
      if (out_valid) ov_count++;
    end
  end

  task automatic send(input logic [1:0] m0, input logic [1:0] mr, input logic [DW*NS-1:0] w,
                      input logic [DW*NS-1:0] g, input logic [DW*NS-1:0] d, input int nb,
                      output int t0);
    t0 = cyc;
    for (int i = 0; i < nb; i++) begin
      in_valid = 1'b1;
      mode = (i == 0) ? m0 : mr;
      W = w[DW*i +: DW]; V_GS = g[DW*i +: DW]; V_DS = d[DW*i +: DW];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string nm, input logic [OW-1:0] exp, input int t0);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk({nm, "_seen"}, 32'(got), 32'd1);
    chk({nm, "_val"}, 32'(out_n), 32'(exp));
    chk({nm, "_lat"}, 32'(cyc - t0), 32'(NS + 1));
    @(negedge clk);
    chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_ov"}, 32'(out_valid), 32'd0);
    chk({nm, "_out_n"}, 32'(out_n), 32'd0);
    chk({nm, "_mode"}, 32'(smc_mode), 32'd0);
    chk({nm, "_w"}, 32'(smc_w), 32'd0);
    chk({nm, "_vgs"}, 32'(smc_vgs), 32'd0);
    chk({nm, "_vds"}, 32'(smc_vds), 32'd0);
  endtask

  typedef struct {
    logic [1:0]    m;
    logic [DW-1:0] w, g, d;
    logic [OW-1:0] exp;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1000000ns");
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    int   t0, ov0, nb;
    logic [1:0] m0, mr;
    logic [DW*NS-1:0] rw, rg, rd;

    tbl[0] = '{m: 2'b01, w: 3'd1, g: 3'd3, d: 3'd1, exp: 10'd12};
    tbl[1] = '{m: 2'b11, w: 3'd7, g: 3'd7, d: 3'd7, exp: 10'd1008};
    tbl[2] = '{m: 2'b00, w: 3'd3, g: 3'd4, d: 3'd5, exp: 10'd72};
    tbl[3] = '{m: 2'b10, w: 3'd5, g: 3'd3, d: 3'd1, exp: 10'd36};

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Async reset in the middle of LOAD (during beat 3)
    send(2'b11, 2'b11, {NS{3'd7}}, {NS{3'd7}}, {NS{3'd7}}, 3, t0);
    in_valid = 1'b1; mode = 2'b11; W = 3'd7; V_GS = 3'd7; V_DS = 3'd7;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      send(tbl[i].m, tbl[i].m, {NS{tbl[i].w}}, {NS{tbl[i].g}}, {NS{tbl[i].d}}, NS, t0);
      wait_result($sformatf("vec%0d", i), tbl[i].exp, t0);
    end

    // Gap after beat 4 aborts with no strobe; next full pattern is normal
    ov0 = ov_count;
    send(2'b11, 2'b11, {NS{3'd7}}, {NS{3'd7}}, {NS{3'd7}}, 5, t0);
    repeat (12) @(posedge clk);
    #1;
    chk("gap_no_strobe", 32'(ov_count - ov0), 32'd0);
    send(2'b01, 2'b01, {NS{3'd1}}, {NS{3'd3}}, {NS{3'd1}}, NS, t0);
    wait_result("after_gap", 10'd12, t0);

    // Mode only sampled on the first beat
    send(2'b01, 2'b00, {NS{3'd1}}, {NS{3'd3}}, {NS{3'd1}}, NS, t0);
    chk("mode_first_beat", 32'(smc_mode), 32'd1);
    wait_result("mode_hold", 10'd12, t0);

    // in_valid held through EVAL/OUT: ignored, next pattern starts right after OUT
    ov0 = ov_count;
    for (int i = 0; i < 2 * NS + 2; i++) begin
      in_valid = 1'b1;
      mode = 2'($urandom);
      W = 3'($urandom); V_GS = 3'($urandom); V_DS = 3'($urandom);
      @(posedge clk); #1;
      if (i == NS + 2) chk("stream_one_strobe", 32'(ov_count - ov0), 32'd1);
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("stream_two_strobes", 32'(ov_count - ov0), 32'd2);

    // Randomized patterns with occasional gaps and idle spacing
    for (int r = 0; r < 40; r++) begin
      repeat (int'($urandom_range(0, 2))) @(posedge clk);
      #0;
      m0 = 2'($urandom); mr = 2'($urandom);
      rw = 18'($urandom); rg = 18'($urandom); rd = 18'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NS - 1)) : NS;
      send(m0, mr, rw, rg, rd, nb, t0);
      if (nb == NS) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    repeat (12) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
